// File: rtl/ddr3_pkg.sv
// Shared DDR3 application-port definitions: command codes, default widths, arbiter states.
package ddr3_pkg;

   localparam int DDR_AW        = 29;
   localparam int DDR_DW        = 256;
   localparam int DDR_MW        = DDR_DW / 8;
   localparam int DDR_TAG_DEPTH = 16;

   localparam logic [2:0] DDR_CMD_WR = 3'b000;
   localparam logic [2:0] DDR_CMD_RD = 3'b001;

   typedef enum logic {
      ARB_INIT = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ddr3_app_arbiter_if.sv
// Two client command ports plus the DDR3 controller application port.
// master = arbiter view (drives grants and app_*), slave = clients and controller.
interface ddr3_app_arbiter_if #(
   parameter int AW = ddr3_pkg::DDR_AW,
   parameter int DW = ddr3_pkg::DDR_DW,
   parameter int MW = ddr3_pkg::DDR_MW
) ();
   logic          calib_done;
   logic          p0_req, p1_req;
   logic          p0_we, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic [MW-1:0] p0_wmask, p1_wmask;
   logic          p0_gnt, p1_gnt;
   logic          p0_rd_valid, p1_rd_valid;
   logic [DW-1:0] rd_data;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic [AW-1:0] app_addr;
   logic          app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic          app_burst;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;
   logic          busy, err;

   modport master (
      input  calib_done, p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_wdata, p1_wdata, p0_wmask, p1_wmask,
             app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      output p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid, rd_data,
             app_cmd, app_en, app_addr, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end, app_burst, busy, err
   );

   modport slave (
      output calib_done, p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_wdata, p1_wdata, p0_wmask, p1_wmask,
             app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      input  p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid, rd_data,
             app_cmd, app_en, app_addr, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end, app_burst, busy, err
   );
endinterface

// File: rtl/ddr3_app_arbiter_tag_fifo.sv
// Small synchronous FIFO holding the issuing port of each outstanding read.
// Head is valid whenever empty is low; push while full and pop while empty are ignored.
module tag_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/ddr3_app_arbiter.sv
// Round-robin sharing of one DDR3 app port between two single-beat clients; 0-cycle grant.
// Grants stall on app_rdy/app_wdf_rdy/tag-full; read data steered back in issue order.
module ddr3_app_arbiter
   import ddr3_pkg::*;
#(
   parameter int TAG_DEPTH = DDR_TAG_DEPTH
) (
   input logic                clk,
   input logic                rst,
   ddr3_app_arbiter_if.master bus
);
   arb_state_t state;
   logic       last;
   logic       run, wr_ok, rd_ok, elig0, elig1;
   logic       gnt0, gnt1, any_gnt, sel, sel_we;
   logic       tag_full, tag_empty, tag_head, rd_pop;

   assign run   = (state == ARB_RUN) & bus.calib_done & ~rst;
   assign wr_ok = bus.app_rdy & bus.app_wdf_rdy;
   assign rd_ok = bus.app_rdy & ~tag_full;
   assign elig0 = run & bus.p0_req & (bus.p0_we ? wr_ok : rd_ok);
   assign elig1 = run & bus.p1_req & (bus.p1_we ? wr_ok : rd_ok);

   // Port 1 wins a tie only when port 0 was granted last.
   assign gnt1    = elig1 & (~elig0 | ~last);
   assign gnt0    = elig0 & ~gnt1;
   assign any_gnt = gnt0 | gnt1;
   assign sel     = gnt1;
   assign sel_we  = sel ? bus.p1_we : bus.p0_we;

   assign bus.p0_gnt       = gnt0;
   assign bus.p1_gnt       = gnt1;
   assign bus.app_en       = any_gnt;
   assign bus.app_cmd      = (any_gnt & ~sel_we) ? DDR_CMD_RD : DDR_CMD_WR;
   assign bus.app_addr     = sel ? bus.p1_addr  : bus.p0_addr;
   assign bus.app_wdf_data = sel ? bus.p1_wdata : bus.p0_wdata;
   assign bus.app_wdf_mask = sel ? bus.p1_wmask : bus.p0_wmask;
   assign bus.app_wdf_wren = any_gnt & sel_we;
   assign bus.app_wdf_end  = any_gnt & sel_we;
   assign bus.app_burst    = 1'b0;

   assign rd_pop          = bus.app_rd_data_valid & ~rst & ~tag_empty;
   assign bus.p0_rd_valid = rd_pop & ~tag_head;
   assign bus.p1_rd_valid = rd_pop & tag_head;
   assign bus.rd_data     = bus.app_rd_data;
   assign bus.busy        = ~tag_empty;

   tag_fifo #(.DEPTH(TAG_DEPTH), .W(1)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (any_gnt & ~sel_we),
      .din   (sel),
      .pop   (rd_pop),
      .head  (tag_head),
      .full  (tag_full),
      .empty (tag_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_INIT;
         last  <= 1'b1;
         bus.err <= 1'b0;
      end else begin
         case (state)
            ARB_INIT: if (bus.calib_done)  state <= ARB_RUN;
            ARB_RUN:  if (!bus.calib_done) state <= ARB_INIT;
            default:  state <= ARB_INIT;
         endcase
         if (any_gnt) last <= sel;
         if (bus.app_rd_data_valid & tag_empty) bus.err <= 1'b1;
      end
   end
endmodule
